// File: rtl/generador_eventos_pkg.sv
// rtl/generador_eventos_pkg.sv - shared state encoding and default widths
// Purpose: state encoding and default field widths used by the event-train generator.
// Contents: N_DEF (pulse-count width), P_DEF (period width), estado_t (2-bit FSM states).
package generador_eventos_pkg;

  localparam int N_DEF = 4;
  localparam int P_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    FIN   = 2'd3
  } estado_t;

endpackage

// File: rtl/generador_eventos_if.sv
// rtl/generador_eventos_if.sv - control/status bundle of the event-train generator
// Purpose: groups the request inputs and train status outputs of generador_eventos.
// Signals: start, stop, num[N], periodo[P] (requester -> generator);
//          pulso, busy, done, restantes[N] (generator -> requester).
// Modports: master = requester side, slave = generator side.
interface generador_eventos_if
  import generador_eventos_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int P = P_DEF
) ();

  logic         start;
  logic         stop;
  logic [N-1:0] num;
  logic [P-1:0] periodo;
  logic         pulso;
  logic         busy;
  logic         done;
  logic [N-1:0] restantes;

  modport master (
    output start, stop, num, periodo,
    input  pulso, busy, done, restantes
  );

  modport slave (
    input  start, stop, num, periodo,
    output pulso, busy, done, restantes
  );

endinterface

// File: rtl/generador_eventos_temporizador.sv
// rtl/generador_eventos_temporizador.sv - loadable down-counter timing the gap between pulses
// Purpose: P-bit down-counter; o_fin flags the last cycle of a gap.
// Ports: i_clk, i_rst (async, active-low), i_load/i_valor (load count),
//        i_en (count down), o_fin (count equals 1).
module temporizador_periodo
  import generador_eventos_pkg::*;
#(
  parameter int P = P_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [P-1:0] i_valor,
  input  logic         i_en,
  output logic         o_fin
);

  localparam logic [P-1:0] UNO = {{(P-1){1'b0}}, 1'b1};

  logic [P-1:0] r_cuenta;

  // Saturates at zero so a stray enable can never wrap the count.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cuenta <= '0;
    end else if (i_load) begin
      r_cuenta <= i_valor;
    end else if (i_en && (r_cuenta != '0)) begin
      r_cuenta <= r_cuenta - UNO;
    end
  end

  assign o_fin = (r_cuenta == UNO);

endmodule

// File: rtl/generador_eventos.sv
// rtl/generador_eventos.sv - programmable event-train generator
// Purpose: on an accepted start, emits num one-cycle pulses spaced periodo idle
//          cycles apart, then a one-cycle done strobe.
// Ports: i_clk, i_rst (async, active-low), bus (slave modport: start, stop, num,
//        periodo in; pulso, busy, done, restantes out).
module generador_eventos
  import generador_eventos_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int P = P_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  generador_eventos_if.slave   bus
);

  localparam logic [N-1:0] UNO_N = {{(N-1){1'b0}}, 1'b1};

  estado_t      r_estado;
  estado_t      w_estado_nxt;
  logic [N-1:0] r_restantes;
  logic [N-1:0] w_restantes_nxt;
  logic [N-1:0] w_rest_dec;
  logic [P-1:0] r_periodo;
  logic         w_acepta;
  logic         w_tmr_load;
  logic         w_tmr_en;
  logic         w_tmr_fin;

  // restantes is always >= 1 in PULSE; the guard keeps it from ever wrapping.
  assign w_rest_dec = (r_restantes != '0) ? (r_restantes - UNO_N) : '0;

  temporizador_periodo #(.P(P)) u_temporizador (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_tmr_load),
    .i_valor (r_periodo),
    .i_en    (w_tmr_en),
    .o_fin   (w_tmr_fin)
  );

  always_comb begin
    w_estado_nxt    = r_estado;
    w_restantes_nxt = r_restantes;
    w_acepta        = 1'b0;
    w_tmr_load      = 1'b0;
    w_tmr_en        = 1'b0;
    unique case (r_estado)
      IDLE, FIN: begin
        // stop blocks acceptance, so a simultaneous start is dropped.
        if (bus.start && !bus.stop) begin
          w_acepta        = 1'b1;
          w_restantes_nxt = bus.num;
          w_estado_nxt    = (bus.num != '0) ? PULSE : FIN;
        end else begin
          w_estado_nxt = IDLE;
        end
      end
      PULSE: begin
        if (bus.stop) begin
          w_estado_nxt    = IDLE;
          w_restantes_nxt = '0;
        end else begin
          w_restantes_nxt = w_rest_dec;
          if (w_rest_dec == '0) begin
            w_estado_nxt = FIN;
          end else if (r_periodo == '0) begin
            w_estado_nxt = PULSE;
          end else begin
            w_estado_nxt = GAP;
            w_tmr_load   = 1'b1;
          end
        end
      end
      GAP: begin
        if (bus.stop) begin
          w_estado_nxt    = IDLE;
          w_restantes_nxt = '0;
        end else begin
          w_tmr_en = 1'b1;
          if (w_tmr_fin) begin
            w_estado_nxt = PULSE;
          end
        end
      end
      default: begin
        w_estado_nxt    = IDLE;
        w_restantes_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_estado    <= IDLE;
      r_restantes <= '0;
      r_periodo   <= '0;
    end else begin
      r_estado    <= w_estado_nxt;
      r_restantes <= w_restantes_nxt;
      if (w_acepta) begin
        r_periodo <= bus.periodo;
      end
    end
  end

  // Moore outputs: decoded from the state register only.
  assign bus.pulso     = (r_estado == PULSE);
  assign bus.busy      = (r_estado == PULSE) || (r_estado == GAP);
  assign bus.done      = (r_estado == FIN);
  assign bus.restantes = r_restantes;

endmodule

// File: tb/tb_generador_eventos.sv
// tb/tb_generador_eventos.sv - scoreboard bench for generador_eventos
module tb_generador_eventos;

  localparam int N = 4;
  localparam int P = 8;

  typedef struct {
    bit es_done;
    int ciclo;
    int rest;
    int cuenta;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  generador_eventos_if #(.N(N), .P(P)) bus ();

  generador_eventos #(.N(N), .P(P)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   busy_ini = 1;
  int   busy_fin = 0;
  int   fin_ciclo = 0;
  ev_t  cola[$];

  logic       clr_cnt = 1'b0;
  logic [3:0] ev_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  // Loopback event counter fed by pulso.
  always @(posedge clk) begin
    if (clr_cnt) ev_cnt <= 4'd0;
    else if (bus.pulso) ev_cnt <= ev_cnt + 4'd1;
  end

  task automatic chk(input string nombre, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", nombre, cyc, act, exp);
    end
  endtask

  // Reference model: a train accepted in cycle c0 yields pulse k in
  // c0+1+k*(per+1) and done one cycle after the last pulse.
  task automatic planificar(input int num, input int per, input int c0);
    for (int k = 0; k < num; k++)
      cola.push_back('{1'b0, c0 + 1 + k * (per + 1), num - k, 0});
    fin_ciclo = (num == 0) ? c0 + 1 : c0 + 1 + (num - 1) * (per + 1) + 1;
    cola.push_back('{1'b1, fin_ciclo, 0, num});
    busy_ini = c0 + 1;
    busy_fin = fin_ciclo - 1;
  endtask

  // Called and returns at posedge+1.
  task automatic estimulo(input bit strt, input bit stp, input int num, input int per);
    bit   ocupado;
    ev_t  tmp[$];
    logic [31:0] vn;
    logic [31:0] vp;
    vn = num;
    vp = per;
    ocupado = (cyc >= busy_ini) && (cyc <= busy_fin);
    bus.start   = strt;
    bus.stop    = stp;
    bus.num     = vn[N-1:0];
    bus.periodo = vp[P-1:0];
    if (stp && ocupado) begin
      foreach (cola[i]) if (cola[i].ciclo <= cyc) tmp.push_back(cola[i]);
      cola = tmp;
      busy_fin = cyc;
    end else if (strt && !stp && !ocupado) begin
      planificar(num, per, cyc);
      clr_cnt = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    clr_cnt   = 1'b0;
  endtask

  task automatic esperar_hasta(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ciclos(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic consumir(input bit es_done);
    ev_t e;
    if (cola.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event @cycle %0d: got done=%0d pulso=%0d expected none",
               cyc, bus.done, bus.pulso);
    end else begin
      e = cola.pop_front();
      chk("event_kind", es_done, e.es_done);
      chk("event_cycle", cyc, e.ciclo);
      chk("restantes", int'(bus.restantes), e.rest);
      if (es_done) chk("loopback_count", int'(ev_cnt), e.cuenta);
    end
  endtask

  // Monitor: compares whenever the DUT presents an event, plus busy each cycle.
  always @(negedge clk) begin
    chk("busy", int'(bus.busy), int'((cyc >= busy_ini) && (cyc <= busy_fin)));
    if (bus.pulso) consumir(1'b0);
    if (bus.done)  consumir(1'b1);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int c0;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.num     = '0;
    bus.periodo = '0;

    // Reset state
    rst = 1'b0;
    ciclos(3);
    chk("reset_pulso", int'(bus.pulso), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_restantes", int'(bus.restantes), 0);
    #2 rst = 1'b1;
    ciclos(2);

    // num=3, periodo=2
    estimulo(1'b1, 1'b0, 3, 2);
    esperar_hasta(fin_ciclo);
    ciclos(3);

    // num=4, periodo=0, then back-to-back num=1
    estimulo(1'b1, 1'b0, 4, 0);
    esperar_hasta(fin_ciclo);
    estimulo(1'b1, 1'b0, 1, 0);
    esperar_hasta(fin_ciclo);
    ciclos(3);

    // num=0: done only
    estimulo(1'b1, 1'b0, 0, 7);
    ciclos(3);

    // Start during busy is ignored
    c0 = cyc;
    estimulo(1'b1, 1'b0, 5, 3);
    esperar_hasta(c0 + 3);
    estimulo(1'b1, 1'b0, 2, 0);
    esperar_hasta(fin_ciclo);
    ciclos(3);

    // Stop in cycle 5 of num=5, periodo=1
    c0 = cyc;
    estimulo(1'b1, 1'b0, 5, 1);
    esperar_hasta(c0 + 5);
    estimulo(1'b0, 1'b1, 0, 0);
    chk("stop_restantes", int'(bus.restantes), 0);
    chk("stop_busy", int'(bus.busy), 0);
    ciclos(12);

    // Stop has priority over start in IDLE
    estimulo(1'b1, 1'b1, 3, 1);
    ciclos(6);

    // Async reset mid-GAP
    c0 = cyc;
    estimulo(1'b1, 1'b0, 3, 6);
    esperar_hasta(c0 + 3);
    #2;
    cola.delete();
    busy_fin = cyc - 1;
    rst = 1'b0;
    #1;
    chk("async_rst_pulso", int'(bus.pulso), 0);
    chk("async_rst_busy", int'(bus.busy), 0);
    chk("async_rst_done", int'(bus.done), 0);
    chk("async_rst_restantes", int'(bus.restantes), 0);
    ciclos(2);
    #2 rst = 1'b1;
    ciclos(20);

    // Randomized trains with loopback counting
    for (int it = 0; it < 30; it++) begin
      int nn;
      int pp;
      int cs;
      nn = int'($urandom_range(15, 1));
      pp = ($urandom_range(3, 0) == 0) ? int'($urandom_range(20, 0)) : int'($urandom_range(3, 0));
      cs = cyc;
      estimulo(1'b1, 1'b0, nn, pp);
      if (nn > 1 && $urandom_range(1, 0) == 1) begin
        esperar_hasta(cs + 2);
        estimulo(1'b1, 1'b0, int'($urandom_range(15, 0)), int'($urandom_range(5, 0)));
      end
      esperar_hasta(fin_ciclo);
      if ($urandom_range(1, 0) == 1) ciclos(int'($urandom_range(3, 1)));
    end

    ciclos(5);
    chk("scoreboard_drained", cola.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
